// File: rtl/mapu_nxn.sv
// rtl/mapu_nxn.sv - DIMxDIM matrix add/sub/mult/transpose unit with row streaming
//
// Loads matrix A (and B unless transposing) one row per handshake, computes one
// result row per cycle, then streams result rows out under downstream flow control.
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   synchronous active-low reset
//   i_vld    in   input row valid
//   o_rdy    out  input row accepted (LOAD_A / LOAD_B only)
//   i_op     in   00 add, 01 sub, 10 mult, 11 transpose(A); latched on A row 0
//   i_sat    in   1 saturate, 0 wrap modulo 2^DATA_WIDTH; latched on A row 0
//   i_row    in   input row, element 0 in LSBs
//   o_vld    out  result row valid
//   i_rdy    in   downstream accepts result row
//   o_row    out  result row, element 0 in LSBs
//   o_ovf    out  any element of this operation clamped or wrapped
//   o_busy   out  an operation is in progress
module mapu_nxn #(
    parameter int DATA_WIDTH = 8,
    parameter int DIM        = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_vld,
    output logic                      o_rdy,
    input  logic [1:0]                i_op,
    input  logic                      i_sat,
    input  logic [DIM*DATA_WIDTH-1:0] i_row,
    output logic                      o_vld,
    input  logic                      i_rdy,
    output logic [DIM*DATA_WIDTH-1:0] o_row,
    output logic                      o_ovf,
    output logic                      o_busy
);

    localparam int CNT_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int ACC_W = 2 * DATA_WIDTH + $clog2(DIM);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIM - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, UNLOAD} state_t;

    state_t                      state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [1:0]                  op_q;
    logic                        sat_q;
    logic                        ovf_acc_q;
    logic                        o_vld_q;
    logic                        o_ovf_q;
    logic [DIM*DATA_WIDTH-1:0]   o_row_q;
    logic [DATA_WIDTH-1:0]       a_q [DIM][DIM];
    logic [DATA_WIDTH-1:0]       b_q [DIM][DIM];
    logic [DATA_WIDTH-1:0]       c_q [DIM][DIM];

    logic [DATA_WIDTH-1:0]       row_d [DIM];
    logic                        row_ovf_d;
    logic [ACC_W-1:0]            acc;
    logic                        neg;
    logic [CNT_W-1:0]            cnt_nxt;

    assign cnt_nxt = cnt_q + 1'b1;

    function automatic logic [ACC_W-1:0] ext(input logic [DATA_WIDTH-1:0] x);
        return {{(ACC_W - DATA_WIDTH){1'b0}}, x};
    endfunction

    // Result row cnt_q, computed at full width and then reduced to DATA_WIDTH.
    always_comb begin
        row_ovf_d = 1'b0;
        acc       = '0;
        neg       = 1'b0;
        for (int c = 0; c < DIM; c++) begin
            acc      = '0;
            neg      = 1'b0;
            row_d[c] = '0;
            case (op_q)
                2'b00: acc = ext(a_q[cnt_q][c]) + ext(b_q[cnt_q][c]);
                2'b01: begin
                    acc = ext(a_q[cnt_q][c]) - ext(b_q[cnt_q][c]);
                    neg = a_q[cnt_q][c] < b_q[cnt_q][c];
                end
                2'b10: begin
                    for (int k = 0; k < DIM; k++) begin
                        acc = acc + ext(a_q[cnt_q][k]) * ext(b_q[k][c]);
                    end
                end
                default: acc = ext(a_q[c][cnt_q]);
            endcase
            // Low bits of a two's-complement difference are already the modulo result.
            if (op_q == 2'b11) begin
                row_d[c] = acc[DATA_WIDTH-1:0];
            end else if (neg) begin
                row_ovf_d = 1'b1;
                row_d[c]  = sat_q ? '0 : acc[DATA_WIDTH-1:0];
            end else if (acc[ACC_W-1:DATA_WIDTH] != '0) begin
                row_ovf_d = 1'b1;
                row_d[c]  = sat_q ? '1 : acc[DATA_WIDTH-1:0];
            end else begin
                row_d[c] = acc[DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= LOAD_A;
            cnt_q     <= '0;
            op_q      <= '0;
            sat_q     <= 1'b0;
            ovf_acc_q <= 1'b0;
            o_vld_q   <= 1'b0;
            o_ovf_q   <= 1'b0;
            o_row_q   <= '0;
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                    c_q[r][c] <= '0;
                end
            end
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (i_vld) begin
                        for (int c = 0; c < DIM; c++) begin
                            a_q[cnt_q][c] <= i_row[c*DATA_WIDTH +: DATA_WIDTH];
                        end
                        if (cnt_q == '0) begin
                            op_q  <= i_op;
                            sat_q <= i_sat;
                        end
                        if (cnt_q == LAST) begin
                            cnt_q     <= '0;
                            ovf_acc_q <= 1'b0;
                            state_q   <= (op_q == 2'b11) ? COMPUTE : LOAD_B;
                        end else begin
                            cnt_q <= cnt_nxt;
                        end
                    end
                end
                LOAD_B: begin
                    if (i_vld) begin
                        for (int c = 0; c < DIM; c++) begin
                            b_q[cnt_q][c] <= i_row[c*DATA_WIDTH +: DATA_WIDTH];
                        end
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            state_q <= COMPUTE;
                        end else begin
                            cnt_q <= cnt_nxt;
                        end
                    end
                end
                COMPUTE: begin
                    c_q[cnt_q] <= row_d;
                    ovf_acc_q  <= ovf_acc_q | row_ovf_d;
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= UNLOAD;
                    end else begin
                        cnt_q <= cnt_nxt;
                    end
                end
                default: begin
                    // First UNLOAD cycle presents row 0; afterwards advance on handshake.
                    if (!o_vld_q) begin
                        o_vld_q <= 1'b1;
                        o_ovf_q <= ovf_acc_q;
                        for (int c = 0; c < DIM; c++) begin
                            o_row_q[c*DATA_WIDTH +: DATA_WIDTH] <= c_q[cnt_q][c];
                        end
                    end else if (i_rdy) begin
                        if (cnt_q == LAST) begin
                            o_vld_q <= 1'b0;
                            o_ovf_q <= 1'b0;
                            o_row_q <= '0;
                            cnt_q   <= '0;
                            state_q <= LOAD_A;
                        end else begin
                            cnt_q <= cnt_nxt;
                            for (int c = 0; c < DIM; c++) begin
                                o_row_q[c*DATA_WIDTH +: DATA_WIDTH] <= c_q[cnt_nxt][c];
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign o_rdy  = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign o_busy = (state_q != LOAD_A) || (cnt_q != '0);
    assign o_vld  = o_vld_q;
    assign o_row  = o_row_q;
    assign o_ovf  = o_ovf_q;

endmodule

// File: tb/tb_mapu_nxn.sv
// tb/tb_mapu_nxn.sv - self-checking bench for mapu_nxn (DATA_WIDTH=8, DIM=4)
module tb_mapu_nxn;

    localparam int W = 8;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_vld;
    logic          o_rdy;
    logic [1:0]    i_op;
    logic          i_sat;
    logic [31:0]   i_row;
    logic          o_vld;
    logic          i_rdy;
    logic [31:0]   o_row;
    logic          o_ovf;
    logic          o_busy;

    always #5 clk = ~clk;

    mapu_nxn #(.DATA_WIDTH(W), .DIM(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_vld   (i_vld),
        .o_rdy   (o_rdy),
        .i_op    (i_op),
        .i_sat   (i_sat),
        .i_row   (i_row),
        .o_vld   (o_vld),
        .i_rdy   (i_rdy),
        .o_row   (o_row),
        .o_ovf   (o_ovf),
        .o_busy  (o_busy)
    );

    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    logic [31:0] exp_q[$];
    logic        exp_ovf_q[$];
    logic [31:0] cap_q[$];
    logic        cap_ovf_q[$];
    int          ma[4][4];
    int          mb[4][4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // mode -1: A[r][c]=4r+c, -2: identity, >=0: every element equals mode
    task automatic set_mats(input int amode, input int bmode);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = (amode == -1) ? 4*r + c : (amode == -2) ? int'(r == c) : amode;
                mb[r][c] = (bmode == -1) ? 4*r + c : (bmode == -2) ? int'(r == c) : bmode;
            end
        end
    endtask

    function automatic logic [31:0] row_of(input bit use_b, input int r);
        logic [31:0] x;
        int v;
        x = '0;
        for (int c = 0; c < 4; c++) begin
            v = use_b ? mb[r][c] : ma[r][c];
            x[c*8 +: 8] = v[7:0];
        end
        return x;
    endfunction

    task automatic push_model(input logic [1:0] op, input logic sat);
        logic [31:0] rows[4];
        logic        ovf;
        int          v;
        ovf = 1'b0;
        for (int r = 0; r < 4; r++) begin
            rows[r] = '0;
            for (int c = 0; c < 4; c++) begin
                case (op)
                    2'b00: v = ma[r][c] + mb[r][c];
                    2'b01: v = ma[r][c] - mb[r][c];
                    2'b10: begin
                        v = 0;
                        for (int k = 0; k < 4; k++) v += ma[r][k] * mb[k][c];
                    end
                    default: v = ma[c][r];
                endcase
                if (op != 2'b11) begin
                    if (v > 255) begin
                        ovf = 1'b1;
                        v = sat ? 255 : (v & 255);
                    end else if (v < 0) begin
                        ovf = 1'b1;
                        v = sat ? 0 : (v & 255);
                    end
                end
                rows[r][c*8 +: 8] = v[7:0];
            end
        end
        for (int r = 0; r < 4; r++) begin
            exp_q.push_back(rows[r]);
            exp_ovf_q.push_back(ovf);
        end
    endtask

    task automatic send_beat(input logic [31:0] row, input logic [1:0] op, input logic sat);
        int n;
        i_vld = 1'b1;
        i_row = row;
        i_op  = op;
        i_sat = sat;
        n = 0;
        while (!o_rdy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rdy_wait", o_rdy, 1);
        @(posedge clk); #1;
        i_vld = 1'b0;
    endtask

    // op/sat are valid only on A beat 0; later beats carry inverted values that must be ignored.
    task automatic run_op(input logic [1:0] op, input logic sat, input bit measure);
        int n;
        push_model(op, sat);
        for (int r = 0; r < 4; r++) begin
            send_beat(row_of(1'b0, r), (r == 0) ? op : ~op, (r == 0) ? sat : ~sat);
            if (r == 0) chk("busy_after_a0", o_busy, 1);
        end
        if (op != 2'b11) begin
            for (int r = 0; r < 4; r++) send_beat(row_of(1'b1, r), ~op, ~sat);
        end
        chk("rdy_after_load", o_rdy, 0);
        if (measure) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!o_vld && n < 20);
            chk("latency", n, N + 1);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_vld) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle", (exp_q.size() == 0 && !o_vld), 1);
    endtask

    task automatic wait_row(input int k);
        int n;
        n = 0;
        while (!(o_vld && acc_cnt == k) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_row", (o_vld && acc_cnt == k), 1);
    endtask

    task automatic cap_clear();
        cap_q.delete();
        cap_ovf_q.delete();
    endtask

    // Single compare process: every cycle with o_vld, the output must match the model front.
    always @(negedge clk) begin
        if (reset_n && o_vld) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_vld", o_vld, 0);
            end else begin
                chk("row", o_row, exp_q[0]);
                chk("ovf", o_ovf, exp_ovf_q[0]);
                if (i_rdy) begin
                    cap_q.push_back(o_row);
                    cap_ovf_q.push_back(o_ovf);
                    void'(exp_q.pop_front());
                    void'(exp_ovf_q.pop_front());
                    acc_cnt++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        i_vld   = 1'b0;
        i_op    = 2'b00;
        i_sat   = 1'b0;
        i_row   = '0;
        i_rdy   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", o_vld, 0);
        chk("rst_rdy", o_rdy, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_row", o_row, 0);
        chk("rst_ovf", o_ovf, 0);
        reset_n = 1'b1;

        // Add
        set_mats(-1, 1); cap_clear();
        run_op(2'b00, 1'b0, 1'b1); wait_idle();
        chk("add_n", cap_q.size(), 4);
        chk("add_r0", cap_q[0], 32'h04030201);
        chk("add_r3", cap_q[3], 32'h100F0E0D);
        chk("add_ovf", cap_ovf_q[0], 0);

        // Mult by identity
        set_mats(-1, -2); cap_clear();
        run_op(2'b10, 1'b1, 1'b1); wait_idle();
        chk("mul_id_r2", cap_q[2], 32'h0B0A0908);
        chk("mul_id_ovf", cap_ovf_q[2], 0);

        // Mult overflow, saturating then wrapping
        set_mats(16, 16); cap_clear();
        run_op(2'b10, 1'b1, 1'b0); wait_idle();
        chk("mul_sat_r0", cap_q[0], 32'hFFFFFFFF);
        chk("mul_sat_ovf", cap_ovf_q[0], 1);
        cap_clear();
        run_op(2'b10, 1'b0, 1'b0); wait_idle();
        chk("mul_wrap_r3", cap_q[3], 32'h00000000);
        chk("mul_wrap_ovf", cap_ovf_q[3], 1);

        // Sub underflow
        set_mats(5, 7); cap_clear();
        run_op(2'b01, 1'b1, 1'b0); wait_idle();
        chk("sub_sat_r1", cap_q[1], 32'h00000000);
        chk("sub_sat_ovf", cap_ovf_q[1], 1);
        cap_clear();
        run_op(2'b01, 1'b0, 1'b0); wait_idle();
        chk("sub_wrap_r2", cap_q[2], 32'hFEFEFEFE);
        chk("sub_wrap_ovf", cap_ovf_q[2], 1);

        // Transpose: A only
        set_mats(-1, 200); cap_clear();
        run_op(2'b11, 1'b1, 1'b1); wait_idle();
        chk("tr_r1", cap_q[1], 32'h0D090501);
        chk("tr_ovf", cap_ovf_q[1], 0);

        // Backpressure on row 1
        set_mats(-1, 1); cap_clear(); acc_cnt = 0;
        run_op(2'b00, 1'b0, 1'b0);
        wait_row(1);
        i_rdy = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_vld", o_vld, 1);
            chk("bp_row", o_row, 32'h08070605);
        end
        i_rdy = 1'b1;
        wait_idle();
        chk("bp_n", cap_q.size(), 4);
        chk("bp_r1", cap_q[1], 32'h08070605);
        chk("bp_r2", cap_q[2], 32'h0C0B0A09);

        // Reset while row 2 is presented
        set_mats(-1, 1); cap_clear(); acc_cnt = 0;
        run_op(2'b00, 1'b0, 1'b0);
        wait_row(2);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_vld", o_vld, 0);
        chk("mid_rst_rdy", o_rdy, 1);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_row", o_row, 0);
        exp_q.delete();
        exp_ovf_q.delete();
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_quiet", o_vld, 0);
        set_mats(-1, 2); cap_clear();
        run_op(2'b00, 1'b0, 1'b1); wait_idle();
        chk("post_rst_r0", cap_q[0], 32'h05040302);
        chk("post_rst_n", cap_q.size(), 4);

        // Next op offered while the previous one computes/unloads
        set_mats(-1, 0); cap_clear();
        run_op(2'b11, 1'b0, 1'b0);
        set_mats(1, 2);
        run_op(2'b00, 1'b0, 1'b0);
        wait_idle();
        chk("chain_n", cap_q.size(), 8);
        chk("chain_tr_r1", cap_q[1], 32'h0D090501);
        chk("chain_add_r0", cap_q[4], 32'h03030303);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mapu_nxn.md
MAPU_NXN -- requirements
Module: mapu_nxn

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, unsigned element width in bits (legal 4..16).
REQ-002 SHALL provide parameter DIM, default 4, matrix dimension DIMxDIM (legal 2..8).
REQ-003 SHALL provide port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL provide port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port i_vld  input  1  input row valid.
REQ-006 SHALL provide port o_rdy  output  1  block accepts an input row.
REQ-007 SHALL provide port i_op  input  2  operation: 00 add, 01 sub, 10 mult, 11 transpose(A).
REQ-008 SHALL provide port i_sat  input  1  1 = saturating arithmetic, 0 = modulo 2^DATA_WIDTH.
REQ-009 SHALL provide port i_row  input  DIM*DATA_WIDTH  input row; element 0 in LSBs.
REQ-010 SHALL provide port o_vld  output  1  output row valid.
REQ-011 SHALL provide port i_rdy  input  1  downstream accepts an output row.
REQ-012 SHALL provide port o_row  output  DIM*DATA_WIDTH  result row; element 0 in LSBs.
REQ-013 SHALL provide port o_ovf  output  1  overflow/underflow flag for the current result, valid while o_vld=1.
REQ-014 SHALL provide port o_busy  output  1  high whenever state is not LOAD_A or any A row has been accepted.

Function
REQ-015 SHALL implement FSM states LOAD_A, LOAD_B, COMPUTE, UNLOAD.
REQ-016 SHALL count an input handshake when i_vld=1 and o_rdy=1; o_rdy SHALL be 1 only in LOAD_A and LOAD_B.
REQ-017 LOAD_A SHALL store beats 0..DIM-1 as A rows 0..DIM-1 and SHALL latch i_op and i_sat on beat 0; later i_op/i_sat changes SHALL be ignored until the next operation.
REQ-018 After A beat DIM-1, SHALL go to LOAD_B for ops 00/01/10, or to COMPUTE for op 11 (B not loaded).
REQ-019 LOAD_B SHALL store DIM beats as B rows 0..DIM-1, then go to COMPUTE.
REQ-020 COMPUTE SHALL last exactly DIM cycles and produce C row r in cycle r; then SHALL go to UNLOAD with o_vld=1 on the next cycle.
REQ-021 Ops: add C[r][c]=A[r][c]+B[r][c]; sub C=A-B; mult C[r][c]=sum_k A[r][k]*B[k][c]; transpose C[r][c]=A[c][r].
REQ-022 Mult SHALL accumulate at full width 2*DATA_WIDTH+clog2(DIM) before the width reduction.
REQ-023 With i_sat=1: results above 2^DATA_WIDTH-1 SHALL clamp to 2^DATA_WIDTH-1, and negative sub results SHALL clamp to 0; with i_sat=0: results SHALL be truncated modulo 2^DATA_WIDTH.
REQ-024 o_ovf SHALL be 1 if any C element clamped or wrapped; it SHALL be constant across all UNLOAD beats of one operation and SHALL never be set by transpose.
REQ-025 UNLOAD SHALL present C rows 0..DIM-1 in order, advancing on o_vld=1 and i_rdy=1; o_row and o_ovf SHALL be held stable while o_vld=1 and i_rdy=0.
REQ-026 After row DIM-1 is accepted, o_vld SHALL drop on the next cycle and state SHALL return to LOAD_A with o_rdy=1 on that same cycle.
REQ-027 Latency: the first o_vld SHALL assert DIM+1 cycles after the final input handshake edge, assuming no stall.
REQ-028 i_vld during COMPUTE/UNLOAD SHALL be ignored, with no data loss; the source SHALL hold i_vld until o_rdy=1.

Reset
REQ-029 While reset_n=0 at a clk edge, the block SHALL set state=LOAD_A, clear all row counters, clear A/B/C and latched op/sat to 0, and drive o_vld=0, o_row=0, o_ovf=0, o_busy=0, o_rdy=1 from the next cycle.
REQ-030 A reset asserted mid-load, mid-compute or mid-unload SHALL abandon the operation with no further output beats.

Verification (DATA_WIDTH=8, DIM=4)
REQ-031 Add: A[r][c]=4r+c, B all 1, op=00 -> 4 beats, C[r][c]=4r+c+1, o_ovf=0, first o_vld 5 cycles after the last B beat.
REQ-032 Mult: A[r][c]=4r+c, B=identity, op=10 -> C==A, o_ovf=0; then A=B=all 16, i_sat=1 -> all 255, o_ovf=1; i_sat=0 -> all 0, o_ovf=1.
REQ-033 Sub: A all 5, B all 7, op=01, i_sat=1 -> all 0, o_ovf=1; i_sat=0 -> all 0xFE, o_ovf=1.
REQ-034 Transpose: op=11, 4 A beats only -> o_rdy=0 after beat 3, C[r][c]=4c+r, o_ovf=0.
REQ-035 Backpressure: i_rdy=0 for 3 cycles on row 1 -> o_vld stays 1, o_row holds row 1, rows still delivered in order 0..3.
REQ-036 Reset during UNLOAD row 2 -> o_vld=0 next cycle, o_rdy=1, and a new add sequence completes correctly afterwards.
